// File: rtl/uart_arb_pkg.sv
// Shared state type and default sizing for the uart_tx arbiter and its helpers.
package uart_arb_pkg;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_DATA_W       = 4;
    localparam int unsigned DEF_BUSY_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RELEASE   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the arbiter, bundled as one interface.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        err;
    logic [IDX_W-1:0]          grant_id;
    logic                      active;
    logic                      uart_tx_en;
    logic [DATA_W-1:0]         uart_tx_data;
    logic                      uart_tx_busy;

    // master: requesters plus the uart_tx transmitter; slave: the arbiter
    modport master (
        output req, req_data, uart_tx_busy,
        input  ack, err, grant_id, active, uart_tx_en, uart_tx_data
    );

    modport slave (
        input  req, req_data, uart_tx_busy,
        output ack, err, grant_id, active, uart_tx_en, uart_tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c
);

    int unsigned cand;

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters, one transfer at a time, round-robin,
// with a bounded wait for the transmitter to report busy after each launch.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input logic              clock,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_en_q, tx_en_d;
    logic               active_q, active_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_REQ-1:0] grant_oh;
    logic [CNT_W-1:0]   cnt_inc;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req     (bus.req),
        .ptr     (rr_ptr_q),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    // Payload slice of the requester the picker would grant now.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_oh = NUM_REQ'(1) << grant_id_q;
    assign cnt_inc  = (cnt_q == CNT_W'(BUSY_TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            tx_en_q    <= 1'b0;
            active_q   <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            tx_en_q    <= tx_en_d;
            active_q   <= active_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        tx_en_d    = 1'b0;
        ack_d      = '0;
        err_d      = '0;

        unique case (state_q)
            IDLE: begin
                // A busy transmitter here is a foreign or residual frame: hold off.
                if (pick_valid && !bus.uart_tx_busy) begin
                    grant_id_d = pick_idx;
                    tx_data_d  = sel_data;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy has priority over a timeout landing in the same cycle.
                if (bus.uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        err_d   = grant_oh;
                        state_d = RELEASE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    ack_d   = grant_oh;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.active       = active_q;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single uart_tx transmitter between NUM_REQ requesters, for example the sum unit, the latch readback and a status source.
- Sits between the requesters and uart_tx. It drives uart_tx_en and uart_tx_data, and watches uart_tx_busy to sequence exactly one transfer at a time.
- Gives each requester a completion pulse (ack) or a failure pulse (err) when its transfer ends.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DATA_W, 4: payload width; matches the uart_tx_data width.
- BUSY_TIMEOUT, 15: maximum number of cycles to wait for uart_tx_busy to rise after launch; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held until that requester's ack or err.
- req_data  input  NUM_REQ*DATA_W  payloads; slice i is req_data[i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-cycle pulse on the granted bit when its transfer completes.
- err  output  NUM_REQ  one-cycle pulse on the granted bit when the busy timeout expires.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- active  output  1  high whenever the state is not IDLE.
- uart_tx_en  output  1  one-cycle launch strobe to uart_tx.
- uart_tx_data  output  DATA_W  registered payload; stable from launch until the return to IDLE.
- uart_tx_busy  input  1  busy flag from uart_tx.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr_ptr = 0; timeout counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: if any req bit is set and uart_tx_busy=0, select the first set bit searching upward from rr_ptr with wrap-around. Latch its index into grant_id and its payload into uart_tx_data. Go to LAUNCH.
  - IDLE while uart_tx_busy=1 (a foreign or residual transfer): stay in IDLE, grant nothing.
  - LAUNCH: uart_tx_en=1 for exactly this one cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if uart_tx_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse err[grant_id] and go to RELEASE.
  - WAIT_DONE: when uart_tx_busy=0, pulse ack[grant_id] and go to RELEASE. There is no timeout in this state; the frame length is owned by uart_tx.
  - RELEASE: one cycle; set rr_ptr = (grant_id+1) mod NUM_REQ; go to IDLE.
- Latency:
  - From req rising while IDLE, uart_tx_en asserts 2 cycles later (IDLE decision registered, then LAUNCH).
  - From the uart_tx_busy falling edge, ack pulses 1 cycle later.
- Turnaround: minimum 2 cycles between ack and the next uart_tx_en (RELEASE, IDLE decision).
- Fairness:
  - A requester that was just served has the lowest priority next time.
  - With all NUM_REQ requesters continuously requesting, the grant order is 0,1,2,3,0,...
- Requester changes during a transfer:
  - Payload is captured at grant, so req_data changes during a transfer are ignored.
  - If the granted requester drops req mid-transfer, the transfer still completes and ack still pulses.
- A req bit that rises during a transfer is considered only at the next IDLE decision.
- Simultaneous events: if busy rises in the same cycle the counter would hit BUSY_TIMEOUT, busy wins and the state goes to WAIT_DONE with no err.
- Reset mid-operation forces IDLE immediately and clears uart_tx_en, ack and err. The in-flight frame in uart_tx is not tracked and is not acknowledged.
- ack and err are never asserted together, and at most one bit of either vector is set in any cycle.
- Widths:
  - timeout counter is $clog2(BUSY_TIMEOUT+1) bits and saturates (never wraps).
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

Decomposition:
- Shared package uart_arb_pkg:
  - enum for the state type: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RELEASE.
  - localparams for the default NUM_REQ, DATA_W and BUSY_TIMEOUT.
- One natural sub-module: rr_pick. It is purely combinational: from req and rr_ptr it produces a valid flag and the selected index. It can be reused by other shared-resource controllers.

Test Plan:
- Single request, model uart_tx busy for 40 cycles: req=4'b0100, data slice 2 = 4'hA → uart_tx_en pulses 2 cycles after req with uart_tx_data=4'hA and grant_id=2; ack=4'b0100 pulses 1 cycle after busy falls; err stays 0.
- All four requesting continuously, distinct payloads 1,2,3,4 → four consecutive transfers with grant order 0,1,2,3 and payloads 1,2,3,4, then 0 again; each req sees exactly one ack per round.
- Busy never rises, BUSY_TIMEOUT=15: req=4'b0001 → err[0] pulses exactly 16 cycles after LAUNCH; no ack; next grant goes to requester 1 if it is requesting.
- Busy already high before any request → no uart_tx_en while busy=1; launch occurs 2 cycles after busy falls.
- Reset asserted in WAIT_DONE → active, uart_tx_en, ack and err all go to 0 asynchronously; after release, rr_ptr=0 and a pending req=4'b1010 grants requester 1 first.
- Payload change: req_data changes mid-transfer and req[1] drops mid-transfer → uart_tx_data holds the captured value and ack[1] still pulses.
